dot_product_engine: RTL and testbench
=====================================

// Module: dot_product_engine
// PURPOSE
//  Compute engine fed by the AXI-Lite configuration register block: on a start edge from the
//  control register, fetches vectors A and B word-by-word over an AXI-Lite read master, computes
//  a signed dot product, writes it over an AXI-Lite write master, and reports status back.
//  Sits directly downstream of the register slave; its STATUS output feeds the status register.
// PARAMETERS
//  ADDR_WIDTH  32  AXI address width; also width of base/output address inputs
//  DATA_WIDTH  32  element/bus data width; elements are signed two's complement
//  ACC_WIDTH   64  accumulator width (>= 2*DATA_WIDTH)
//  MAX_LEN     1024 largest legal vector length
// PORTS
//  ACLK        in   1           clock
//  ARESET      in   1           synchronous reset, active-high
//  START       in   1           control reg bit0; rising edge launches an operation
//  VEC_A_BASE  in   ADDR_WIDTH  byte address of A[0]
//  VEC_B_BASE  in   ADDR_WIDTH  byte address of B[0]
//  VEC_LEN     in   32          element count
//  OUT_ADDR    in   ADDR_WIDTH  byte address for the result
//  STATUS      out  32          [0]busy [1]done [2]error [3]overflow, others 0
//  M_ARADDR/M_ARVALID out, M_ARREADY in      read address channel
//  M_RDATA in DATA_WIDTH, M_RRESP in 2, M_RVALID in, M_RREADY out   read data channel
//  M_AWADDR/M_AWVALID out, M_AWREADY in; M_WDATA out DATA_WIDTH, M_WVALID out, M_WREADY in
//  M_BRESP in 2, M_BVALID in, M_BREADY out   write response channel
// BEHAVIOUR
//  Reset: state IDLE; all VALID/READY outputs 0; addresses, WDATA, STATUS, acc, index = 0.
//  Reset mid-operation aborts immediately; in-flight AXI transactions are abandoned.
//  Start: start_d registers START; launch when START & ~start_d in IDLE. Edges while busy ignored.
//  Launch samples VEC_* and OUT_ADDR into internal regs; later input changes have no effect.
//  Launch clears done/error/overflow, sets busy, acc=0, idx=0.
//  VEC_LEN==0 -> go straight to WRITE with result 0. VEC_LEN>MAX_LEN -> error=1, no bus traffic, DONE.
//  FSM: IDLE -> RD_A_ADDR -> RD_A_DATA -> RD_B_ADDR -> RD_B_DATA -> MAC -> (RD_A_ADDR | WRITE)
//       -> WR_RESP -> DONE -> IDLE.
//  RD_x_ADDR: ARVALID=1, ARADDR=base + idx*(DATA_WIDTH/8); hold stable until ARREADY, then advance.
//  RD_x_DATA: RREADY=1; on RVALID capture RDATA. RRESP!=00 -> error=1, skip to DONE (no write).
//  MAC: acc += sext(a)*sext(b) (full 2*DATA_WIDTH product); idx++; idx==len -> WRITE.
//  One outstanding read at a time; minimum 5 cycles/element with zero-wait slave.
//  WRITE: AWVALID=WVALID=1 same cycle, AWADDR=OUT_ADDR, WDATA=acc[DATA_WIDTH-1:0]; each VALID drops
//    independently on its READY; both handshaken -> WR_RESP.
//  WR_RESP: BREADY=1 until BVALID; BRESP!=00 -> error=1. Then DONE.
//  Overflow: set if final acc outside signed DATA_WIDTH range; result still written truncated.
//  Accumulator wraps modulo 2^ACC_WIDTH; no saturation.
//  DONE: one cycle; busy=0, done=1 (sticky until next launch) -> IDLE.
//  Handshake done in same cycle VALID asserted (READY already high) is legal and must not stall.
// TESTING
//  A=[1,2,3] @0x100, B=[4,5,6] @0x200, len 3, out 0x300, zero-wait -> write 32 to 0x300, STATUS=0x2.
//  A=[-2,7], B=[3,-1] with random ARREADY/RVALID/AWREADY/WREADY stalls -> write 0xFFFF_FFF3, done.
//  len 0 -> no AR traffic, single write of 0, STATUS=0x2; len MAX_LEN+1 -> no traffic, STATUS=0x6.
//  RRESP=10 on B[1] -> no AW/W, STATUS=0x6; BRESP=10 -> STATUS=0x6.
//  A=B=[0x7FFF_FFFF]x2 -> acc 0x7FFF_FFFE_0000_0002, write 0x0000_0002, STATUS=0xA.
//  START held high after done -> no relaunch; ARESET asserted mid-RD_B_DATA -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dot_product_engine.sv
// -----------------------------------------------------------------------------
// dot_product_engine
//
// Purpose:
//   A rising edge on START in IDLE launches one operation. The engine fetches
//   the signed vectors A and B one element at a time over an AXI-Lite read
//   master and accumulates sum(A[i]*B[i]) into an ACC_WIDTH-bit register. It
//   then writes the low DATA_WIDTH bits of the sum to OUT_ADDR over an AXI-Lite
//   write master and reports the outcome on STATUS.
//
// Ports:
//   ACLK, ARESET          clock; synchronous active-high reset
//   START                 control bit; a rising edge launches an operation
//   VEC_A_BASE/VEC_B_BASE byte addresses of A[0] / B[0]
//   VEC_LEN               element count (0 .. MAX_LEN)
//   OUT_ADDR              byte address for the result word
//   STATUS                [0] busy [1] done [2] error [3] overflow
//   M_AR*/M_R*            read master (one outstanding read at a time)
//   M_AW*/M_W*/M_B*       write master (single result write)
// -----------------------------------------------------------------------------
module dot_product_engine #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 64,
   parameter int MAX_LEN    = 1024
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  START,
   input  logic [ADDR_WIDTH-1:0] VEC_A_BASE,
   input  logic [ADDR_WIDTH-1:0] VEC_B_BASE,
   input  logic [31:0]           VEC_LEN,
   input  logic [ADDR_WIDTH-1:0] OUT_ADDR,
   output logic [31:0]           STATUS,
   output logic [ADDR_WIDTH-1:0] M_ARADDR,
   output logic                  M_ARVALID,
   input  logic                  M_ARREADY,
   input  logic [DATA_WIDTH-1:0] M_RDATA,
   input  logic [1:0]            M_RRESP,
   input  logic                  M_RVALID,
   output logic                  M_RREADY,
   output logic [ADDR_WIDTH-1:0] M_AWADDR,
   output logic                  M_AWVALID,
   input  logic                  M_AWREADY,
   output logic [DATA_WIDTH-1:0] M_WDATA,
   output logic                  M_WVALID,
   input  logic                  M_WREADY,
   input  logic [1:0]            M_BRESP,
   input  logic                  M_BVALID,
   output logic                  M_BREADY
);

   localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_A_ADDR,
      S_RD_A_DATA,
      S_RD_B_ADDR,
      S_RD_B_DATA,
      S_MAC,
      S_WRITE,
      S_WR_RESP,
      S_DONE
   } state_t;

   state_t                state_reg;
   logic                  start_d_reg;
   logic [ADDR_WIDTH-1:0] a_base_reg;
   logic [ADDR_WIDTH-1:0] b_base_reg;
   logic [ADDR_WIDTH-1:0] out_addr_reg;
   logic [31:0]           len_reg;
   logic [31:0]           idx_reg;
   logic [DATA_WIDTH-1:0] a_reg;
   logic [DATA_WIDTH-1:0] b_reg;
   logic [ACC_WIDTH-1:0]  acc_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  err_reg;
   logic                  ovf_reg;
   logic [ADDR_WIDTH-1:0] araddr_reg;
   logic                  arvalid_reg;
   logic                  rready_reg;
   logic [ADDR_WIDTH-1:0] awaddr_reg;
   logic                  awvalid_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic                  wvalid_reg;
   logic                  bready_reg;

   // Sign-extend both operands to the accumulator width; since
   // ACC_WIDTH >= 2*DATA_WIDTH the truncated product equals the exact
   // 2*DATA_WIDTH signed product, sign-extended.
   logic [ACC_WIDTH-1:0]  a_ext;
   logic [ACC_WIDTH-1:0]  b_ext;
   logic [ACC_WIDTH-1:0]  prod;
   logic [ACC_WIDTH-1:0]  acc_next;
   logic [31:0]           idx_next;
   logic                  acc_fits;
   logic                  launch;
   logic                  aw_done;
   logic                  w_done;

   assign a_ext    = {{(ACC_WIDTH-DATA_WIDTH){a_reg[DATA_WIDTH-1]}}, a_reg};
   assign b_ext    = {{(ACC_WIDTH-DATA_WIDTH){b_reg[DATA_WIDTH-1]}}, b_reg};
   assign prod     = a_ext * b_ext;
   assign acc_next = acc_reg + prod;
   assign idx_next = idx_reg + 32'd1;

   // The sum fits a signed DATA_WIDTH word when every bit from the word's sign
   // bit upward is identical.
   assign acc_fits = (&acc_next[ACC_WIDTH-1:DATA_WIDTH-1]) |
                     ~(|acc_next[ACC_WIDTH-1:DATA_WIDTH-1]);

   assign launch = START & ~start_d_reg & (state_reg == S_IDLE);

   // A channel counts as finished once its VALID has already dropped or is
   // being accepted in this cycle.
   assign aw_done = ~awvalid_reg | M_AWREADY;
   assign w_done  = ~wvalid_reg  | M_WREADY;

   function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [31:0] idx);
      return base + (ADDR_WIDTH'(idx) << BYTE_SHIFT);
   endfunction

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_reg    <= S_IDLE;
         start_d_reg  <= 1'b0;
         a_base_reg   <= '0;
         b_base_reg   <= '0;
         out_addr_reg <= '0;
         len_reg      <= '0;
         idx_reg      <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         acc_reg      <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         ovf_reg      <= 1'b0;
         araddr_reg   <= '0;
         arvalid_reg  <= 1'b0;
         rready_reg   <= 1'b0;
         awaddr_reg   <= '0;
         awvalid_reg  <= 1'b0;
         wdata_reg    <= '0;
         wvalid_reg   <= 1'b0;
         bready_reg   <= 1'b0;
      end else begin
         start_d_reg <= START;
         case (state_reg)
            S_IDLE: begin
               if (launch) begin
                  a_base_reg   <= VEC_A_BASE;
                  b_base_reg   <= VEC_B_BASE;
                  len_reg      <= VEC_LEN;
                  out_addr_reg <= OUT_ADDR;
                  acc_reg      <= '0;
                  idx_reg      <= '0;
                  busy_reg     <= 1'b1;
                  done_reg     <= 1'b0;
                  err_reg      <= 1'b0;
                  ovf_reg      <= 1'b0;
                  if (VEC_LEN > 32'(MAX_LEN)) begin
                     err_reg   <= 1'b1;
                     state_reg <= S_DONE;
                  end else if (VEC_LEN == 32'd0) begin
                     // Empty vectors still produce a (zero) result write.
                     awaddr_reg  <= OUT_ADDR;
                     wdata_reg   <= '0;
                     awvalid_reg <= 1'b1;
                     wvalid_reg  <= 1'b1;
                     state_reg   <= S_WRITE;
                  end else begin
                     araddr_reg  <= VEC_A_BASE;
                     arvalid_reg <= 1'b1;
                     state_reg   <= S_RD_A_ADDR;
                  end
               end
            end

            S_RD_A_ADDR: begin
               if (M_ARREADY) begin
                  arvalid_reg <= 1'b0;
                  rready_reg  <= 1'b1;
                  state_reg   <= S_RD_A_DATA;
               end
            end

            S_RD_A_DATA: begin
               if (M_RVALID) begin
                  rready_reg <= 1'b0;
                  if (M_RRESP != 2'b00) begin
                     err_reg   <= 1'b1;
                     state_reg <= S_DONE;
                  end else begin
                     a_reg       <= M_RDATA;
                     araddr_reg  <= elem_addr(b_base_reg, idx_reg);
                     arvalid_reg <= 1'b1;
                     state_reg   <= S_RD_B_ADDR;
                  end
               end
            end

            S_RD_B_ADDR: begin
               if (M_ARREADY) begin
                  arvalid_reg <= 1'b0;
                  rready_reg  <= 1'b1;
                  state_reg   <= S_RD_B_DATA;
               end
            end

            S_RD_B_DATA: begin
               if (M_RVALID) begin
                  rready_reg <= 1'b0;
                  if (M_RRESP != 2'b00) begin
                     err_reg   <= 1'b1;
                     state_reg <= S_DONE;
                  end else begin
                     b_reg     <= M_RDATA;
                     state_reg <= S_MAC;
                  end
               end
            end

            S_MAC: begin
               acc_reg <= acc_next;
               idx_reg <= idx_next;
               if (idx_next == len_reg) begin
                  awaddr_reg  <= out_addr_reg;
                  wdata_reg   <= acc_next[DATA_WIDTH-1:0];
                  awvalid_reg <= 1'b1;
                  wvalid_reg  <= 1'b1;
                  ovf_reg     <= ~acc_fits;
                  state_reg   <= S_WRITE;
               end else begin
                  araddr_reg  <= elem_addr(a_base_reg, idx_next);
                  arvalid_reg <= 1'b1;
                  state_reg   <= S_RD_A_ADDR;
               end
            end

            S_WRITE: begin
               if (M_AWREADY) awvalid_reg <= 1'b0;
               if (M_WREADY)  wvalid_reg  <= 1'b0;
               if (aw_done && w_done) begin
                  bready_reg <= 1'b1;
                  state_reg  <= S_WR_RESP;
               end
            end

            S_WR_RESP: begin
               if (M_BVALID) begin
                  bready_reg <= 1'b0;
                  if (M_BRESP != 2'b00) err_reg <= 1'b1;
                  state_reg <= S_DONE;
               end
            end

            S_DONE: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b1;
               state_reg <= S_IDLE;
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign STATUS    = {28'd0, ovf_reg, err_reg, done_reg, busy_reg};
   assign M_ARADDR  = araddr_reg;
   assign M_ARVALID = arvalid_reg;
   assign M_RREADY  = rready_reg;
   assign M_AWADDR  = awaddr_reg;
   assign M_AWVALID = awvalid_reg;
   assign M_WDATA   = wdata_reg;
   assign M_WVALID  = wvalid_reg;
   assign M_BREADY  = bready_reg;

endmodule

// File: tb/tb_dot_product_engine.sv
// -----------------------------------------------------------------------------
// tb_dot_product_engine
//
// Table of operations applied in a loop against a behavioural AXI-Lite slave
// (memory, optional random stalls, injectable RRESP/BRESP errors). Expected
// result writes are queued at launch and matched against writes the slave
// sees. Hand-written sequences cover START held high and reset mid-read.
// -----------------------------------------------------------------------------
module tb_dot_product_engine;

   localparam int MAXL   = 1024;
   localparam logic [31:0] NO_ADDR = 32'hFFFF_FFF0;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        START;
   logic [31:0] VEC_A_BASE, VEC_B_BASE, VEC_LEN, OUT_ADDR;
   logic [31:0] STATUS;
   logic [31:0] M_ARADDR;
   logic        M_ARVALID, M_ARREADY;
   logic [31:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RVALID, M_RREADY;
   logic [31:0] M_AWADDR;
   logic        M_AWVALID, M_AWREADY;
   logic [31:0] M_WDATA;
   logic        M_WVALID, M_WREADY;
   logic [1:0]  M_BRESP;
   logic        M_BVALID, M_BREADY;

   always #5 ACLK = ~ACLK;

   dot_product_engine #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .ACC_WIDTH(64), .MAX_LEN(MAXL)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .START(START),
      .VEC_A_BASE(VEC_A_BASE), .VEC_B_BASE(VEC_B_BASE), .VEC_LEN(VEC_LEN),
      .OUT_ADDR(OUT_ADDR), .STATUS(STATUS),
      .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
      .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
      .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
      .M_WDATA(M_WDATA), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
      .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY)
   );

   // ---------------- slave model ----------------
   logic [31:0] mem [0:1023];
   bit          stall;
   bit          berr;
   logic [31:0] rerr_addr;
   logic [31:0] rblock_addr;
   int          ar_cnt = 0;
   logic        rd_pend, aw_got, w_got, b_pend;
   logic [31:0] rd_addr, aw_addr, w_data;
   logic [63:0] wr_seen [$];
   logic [63:0] exp_q [$];

   always @(posedge ACLK) begin
      if (ARESET) begin
         M_ARREADY <= 1'b0; M_RVALID <= 1'b0; M_RDATA <= '0; M_RRESP <= 2'b00;
         M_AWREADY <= 1'b0; M_WREADY <= 1'b0; M_BVALID <= 1'b0; M_BRESP <= 2'b00;
         rd_pend <= 1'b0; rd_addr <= '0; aw_got <= 1'b0; w_got <= 1'b0;
         aw_addr <= '0; w_data <= '0; b_pend <= 1'b0;
      end else begin
         M_ARREADY <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
         M_AWREADY <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
         M_WREADY  <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (M_ARVALID && M_ARREADY) begin
            ar_cnt  <= ar_cnt + 1;
            rd_pend <= 1'b1;
            rd_addr <= M_ARADDR;
         end
         if (M_RVALID) begin
            if (M_RREADY) M_RVALID <= 1'b0;
         end else if (rd_pend && rd_addr != rblock_addr &&
                      (!stall || $urandom_range(0, 1) == 1)) begin
            M_RVALID <= 1'b1;
            M_RDATA  <= mem[rd_addr[11:2]];
            M_RRESP  <= (rd_addr == rerr_addr) ? 2'b10 : 2'b00;
            rd_pend  <= 1'b0;
         end
         if (M_AWVALID && M_AWREADY && !aw_got) begin
            aw_got <= 1'b1; aw_addr <= M_AWADDR;
         end
         if (M_WVALID && M_WREADY && !w_got) begin
            w_got <= 1'b1; w_data <= M_WDATA;
         end
         if (aw_got && w_got) begin
            wr_seen.push_back({aw_addr, w_data});
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1;
         end
         if (M_BVALID) begin
            if (M_BREADY) M_BVALID <= 1'b0;
         end else if (b_pend && (!stall || $urandom_range(0, 1) == 1)) begin
            M_BVALID <= 1'b1;
            M_BRESP  <= berr ? 2'b10 : 2'b00;
            b_pend   <= 1'b0;
         end
      end
   end

   // ---------------- checking ----------------
   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   typedef struct packed {
      logic [31:0]      a_base;
      logic [31:0]      b_base;
      logic [31:0]      out_addr;
      logic [31:0]      len;
      logic [3:0][31:0] a;
      logic [3:0][31:0] b;
      logic             stall;
      logic             berr;
      logic [31:0]      rerr_addr;
      logic [7:0]       exp_nwr;
      logic [7:0]       exp_ar;
      logic [31:0]      exp_wdata;
      logic [31:0]      exp_status;
   } vec_t;

   localparam int NVEC = 11;
   vec_t tbl [0:NVEC-1];

   function automatic vec_t mk(input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] len,
                               input logic [31:0] oa, input logic [3:0][31:0] a,
                               input logic [3:0][31:0] b, input logic st, input logic be,
                               input logic [31:0] re, input logic [7:0] nwr, input logic [7:0] nar,
                               input logic [31:0] wd, input logic [31:0] sts);
      vec_t v;
      v.a_base = ab; v.b_base = bb; v.len = len; v.out_addr = oa; v.a = a; v.b = b;
      v.stall = st; v.berr = be; v.rerr_addr = re; v.exp_nwr = nwr; v.exp_ar = nar;
      v.exp_wdata = wd; v.exp_status = sts;
      return v;
   endfunction

   task automatic run_vec(input int k, input bit hold);
      vec_t v;
      int   ar0;
      int   cyc;
      int   nwr;
      logic [63:0] got;
      v = tbl[k];
      for (int i = 0; i < 4; i++) begin
         if (32'(i) < v.len) begin
            mem[int'(v.a_base[11:2]) + i] = v.a[i];
            mem[int'(v.b_base[11:2]) + i] = v.b[i];
         end
      end
      stall = v.stall; berr = v.berr; rerr_addr = v.rerr_addr;
      if (v.exp_nwr != 8'd0) exp_q.push_back({v.out_addr, v.exp_wdata});
      @(negedge ACLK);
      VEC_A_BASE = v.a_base; VEC_B_BASE = v.b_base; VEC_LEN = v.len; OUT_ADDR = v.out_addr;
      ar0 = ar_cnt;
      START = 1'b1;
      @(negedge ACLK);
      check($sformatf("v%0d_launch_status", k), 64'({STATUS[3], STATUS[1:0]}), 64'(3'b001));
      if (!hold) START = 1'b0;
      // Inputs sampled at launch must no longer matter.
      VEC_A_BASE = 32'h0000_0F00; VEC_B_BASE = 32'h0000_0F80; VEC_LEN = 32'd5;
      OUT_ADDR = 32'h0BAD_0000;
      if (!hold && v.len != 32'd0 && v.len <= 32'(MAXL)) begin
         @(negedge ACLK); START = 1'b1;   // edge while busy: ignored
         @(negedge ACLK); START = 1'b0;
      end
      cyc = 0;
      while (!(STATUS[1] && !STATUS[0]) && cyc < 4000) begin
         @(negedge ACLK);
         cyc++;
      end
      check($sformatf("v%0d_done_seen", k), 64'(STATUS[1:0]), 64'(2'b10));
      repeat (hold ? 40 : 5) @(negedge ACLK);
      check($sformatf("v%0d_status", k), 64'(STATUS), 64'(v.exp_status));
      check($sformatf("v%0d_ar_count", k), 64'(ar_cnt - ar0), 64'(v.exp_ar));
      nwr = wr_seen.size();
      check($sformatf("v%0d_write_count", k), 64'(nwr), 64'(v.exp_nwr));
      while (wr_seen.size() != 0 && exp_q.size() != 0) begin
         got = wr_seen.pop_front();
         check($sformatf("v%0d_write_addr_data", k), got, exp_q.pop_front());
      end
      wr_seen.delete();
      exp_q.delete();
      START = 1'b0;
      $display("vec %0d: len=%0d status=0x%0h ar=%0d writes=%0d cycles=%0d",
               k, v.len, STATUS, ar_cnt - ar0, nwr, cyc);
   endtask

   initial begin
      int ar0;
      int cyc;
      tbl[0]  = mk(32'h100, 32'h200, 32'd3, 32'h300, {32'd0, 32'd3, 32'd2, 32'd1},
                   {32'd0, 32'd6, 32'd5, 32'd4}, 1'b0, 1'b0, NO_ADDR, 8'd1, 8'd6,
                   32'd32, 32'h2);
      tbl[1]  = mk(32'h400, 32'h480, 32'd2, 32'h500, {32'd0, 32'd0, 32'd7, 32'hFFFF_FFFE},
                   {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd3}, 1'b1, 1'b0, NO_ADDR, 8'd1, 8'd4,
                   32'hFFFF_FFF3, 32'h2);
      tbl[2]  = mk(32'h100, 32'h200, 32'd0, 32'h340, '0, '0, 1'b0, 1'b0, NO_ADDR,
                   8'd1, 8'd0, 32'd0, 32'h2);
      tbl[3]  = mk(32'h100, 32'h200, 32'(MAXL + 1), 32'h340, '0, '0, 1'b0, 1'b0, NO_ADDR,
                   8'd0, 8'd0, 32'd0, 32'h6);
      tbl[4]  = mk(32'h100, 32'h200, 32'd3, 32'h300, {32'd0, 32'd3, 32'd2, 32'd1},
                   {32'd0, 32'd6, 32'd5, 32'd4}, 1'b0, 1'b0, 32'h204, 8'd0, 8'd4,
                   32'd0, 32'h6);
      tbl[5]  = mk(32'h100, 32'h200, 32'd3, 32'h300, {32'd0, 32'd3, 32'd2, 32'd1},
                   {32'd0, 32'd6, 32'd5, 32'd4}, 1'b0, 1'b1, NO_ADDR, 8'd1, 8'd6,
                   32'd32, 32'h6);
      tbl[6]  = mk(32'h600, 32'h680, 32'd2, 32'h700, {32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
                   {32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, 1'b0, 1'b0, NO_ADDR,
                   8'd1, 8'd4, 32'd2, 32'hA);
      tbl[7]  = mk(32'h600, 32'h680, 32'd1, 32'h704, {32'd0, 32'd0, 32'd0, 32'h8000_0000},
                   {32'd0, 32'd0, 32'd0, 32'd1}, 1'b0, 1'b0, NO_ADDR,
                   8'd1, 8'd2, 32'h8000_0000, 32'h2);
      tbl[8]  = mk(32'h600, 32'h680, 32'd2, 32'h708, {32'd0, 32'd0, 32'h4000_0000, 32'h4000_0000},
                   {32'd0, 32'd0, 32'd1, 32'd1}, 1'b0, 1'b0, NO_ADDR,
                   8'd1, 8'd4, 32'h8000_0000, 32'hA);
      tbl[9]  = mk(32'h600, 32'h680, 32'd1, 32'h70C, {32'd0, 32'd0, 32'd0, 32'h8000_0000},
                   {32'd0, 32'd0, 32'd0, 32'h8000_0000}, 1'b1, 1'b0, NO_ADDR,
                   8'd1, 8'd2, 32'd0, 32'hA);
      tbl[10] = mk(32'h800, 32'h880, 32'd4, 32'h900, {4{32'hFFFF_FFFF}},
                   {4{32'd1}}, 1'b1, 1'b0, NO_ADDR, 8'd1, 8'd8, 32'hFFFF_FFFC, 32'h2);

      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      stall = 1'b0; berr = 1'b0; rerr_addr = NO_ADDR; rblock_addr = NO_ADDR;
      ARESET = 1'b1; START = 1'b0;
      VEC_A_BASE = '0; VEC_B_BASE = '0; VEC_LEN = '0; OUT_ADDR = '0;
      repeat (3) @(negedge ACLK);
      check("reset_status", 64'(STATUS), 64'd0);
      check("reset_ctrl", 64'({M_ARVALID, M_RREADY, M_AWVALID, M_WVALID, M_BREADY}), 64'd0);
      check("reset_addr_data", {M_ARADDR, M_WDATA}, 64'd0);
      ARESET = 1'b0;
      repeat (2) @(negedge ACLK);

      for (int k = 0; k < NVEC; k++) run_vec(k, 1'b0);

      // START held high through and after completion must not relaunch.
      run_vec(0, 1'b1);

      // Reset while waiting for B[0] data.
      mem[32'hA00 >> 2] = 32'd1; mem[(32'hA00 >> 2) + 1] = 32'd2;
      mem[32'hB00 >> 2] = 32'd3; mem[(32'hB00 >> 2) + 1] = 32'd4;
      stall = 1'b0; berr = 1'b0; rerr_addr = NO_ADDR; rblock_addr = 32'hB00;
      @(negedge ACLK);
      VEC_A_BASE = 32'hA00; VEC_B_BASE = 32'hB00; VEC_LEN = 32'd2; OUT_ADDR = 32'hC00;
      ar0 = ar_cnt;
      START = 1'b1;
      @(negedge ACLK);
      START = 1'b0;
      cyc = 0;
      while (!((ar_cnt - ar0) == 2 && M_RREADY) && cyc < 200) begin
         @(negedge ACLK);
         cyc++;
      end
      check("midrst_reached_rd_b_data", 64'({(ar_cnt - ar0) == 2, M_RREADY, M_ARADDR}),
            64'({1'b1, 1'b1, 32'hB00}));
      ARESET = 1'b1;
      @(negedge ACLK);
      check("midrst_ctrl", 64'({M_ARVALID, M_RREADY, M_AWVALID, M_WVALID, M_BREADY}), 64'd0);
      check("midrst_addr", {M_ARADDR, M_AWADDR}, 64'd0);
      check("midrst_wdata_status", {M_WDATA, STATUS}, 64'd0);
      $display("midrst: status=0x%0h araddr=0x%0h after reset", STATUS, M_ARADDR);
      ARESET = 1'b0;
      rblock_addr = NO_ADDR;
      repeat (2) @(negedge ACLK);
      wr_seen.delete();

      // Engine recovers normally after the aborted operation.
      run_vec(0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
